// File: rtl/aes_spi_framer.sv
// SPI command framer for an AES core: loads key and plaintext, kicks encryption,
// and returns the ciphertext byte by byte over the same SPI link.
module aes_spi_framer #(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss,
  input  logic                rx_done,
  input  logic [7:0]          rx_byte,
  output logic [7:0]          tx_byte,
  output logic [8*NBYTES-1:0] key,
  output logic [8*NBYTES-1:0] block_in,
  output logic                start,
  input  logic                aes_done,
  input  logic [8*NBYTES-1:0] block_out,
  output logic                busy,
  output logic                err
);

  localparam int PW = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_LOAD_KEY = 3'd2,
    S_LOAD_PT  = 3'd3,
    S_READ     = 3'd4,
    S_DRAIN    = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_shadow;
  logic [PW-1:0]   r_key;
  logic [PW-1:0]   r_block_in;
  logic [PW-1:0]   r_result;
  logic [7:0]      r_tx_byte;
  logic            r_start;
  logic            r_busy;
  logic            r_result_valid;
  logic            r_err;

  logic            w_rx;
  logic            w_last;
  logic            w_done_ok;
  logic            w_busy_eff;
  logic            w_commit_pt;
  logic            w_read_end;
  logic            w_busy_n;
  logic            w_rv_n;
  logic [7:0]      w_status;
  logic [PW-1:0]   w_shift_in;

  // Byte idx of a result word, idx 0 being the most significant byte.
  function automatic logic [7:0] byte_at(input logic [PW-1:0] res, input int unsigned idx);
    logic [PW-1:0] t;
    t = res << (idx * 32'd8);
    return t[PW-1 -: 8];
  endfunction

  // Next-cycle busy/result_valid; aes_done wins over a same-cycle 0x02 command.
  always_comb begin
    w_rx        = rx_done & ~ss;
    w_last      = (r_cnt == CW'(NBYTES - 1));
    w_done_ok   = aes_done & r_busy;
    w_busy_eff  = r_busy & ~aes_done;
    w_commit_pt = (r_state == S_LOAD_PT) & w_rx & w_last;
    w_read_end  = (r_state == S_READ) & w_rx & w_last;
    w_busy_n    = w_busy_eff | w_commit_pt;
    w_rv_n      = w_done_ok | (r_result_valid & ~w_read_end);
    w_status    = {6'b000000, w_busy_n, w_rv_n};
    w_shift_in  = (r_shadow << 8) | PW'(rx_byte);
  end

  // Framer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= {CW{1'b0}};
      r_shadow       <= {PW{1'b0}};
      r_key          <= {PW{1'b0}};
      r_block_in     <= {PW{1'b0}};
      r_result       <= {PW{1'b0}};
      r_tx_byte      <= 8'h00;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_start        <= 1'b0;
      r_busy         <= w_busy_n;
      r_result_valid <= w_rv_n;
      if (w_done_ok) begin
        r_result <= block_out;
      end
      if (ss) begin
        // Frame boundary: any partial payload is dropped.
        r_state   <= S_IDLE;
        r_cnt     <= {CW{1'b0}};
        r_shadow  <= {PW{1'b0}};
        r_tx_byte <= w_status;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_CMD;
            r_tx_byte <= w_status;
          end
          S_CMD: begin
            r_tx_byte <= w_status;
            if (rx_done) begin
              r_cnt    <= {CW{1'b0}};
              r_shadow <= {PW{1'b0}};
              case (rx_byte)
                8'h01: r_state <= S_LOAD_KEY;
                8'h02: begin
                  if (w_busy_eff) begin
                    r_err   <= 1'b1;
                    r_state <= S_DRAIN;
                  end else begin
                    r_state <= S_LOAD_PT;
                  end
                end
                8'h03: begin
                  r_state   <= S_READ;
                  r_tx_byte <= byte_at(r_result, 32'd0);
                end
                default: begin
                  r_err   <= 1'b1;
                  r_state <= S_DRAIN;
                end
              endcase
            end
          end
          S_LOAD_KEY, S_LOAD_PT: begin
            r_tx_byte <= w_status;
            if (rx_done) begin
              if (w_last) begin
                if (r_state == S_LOAD_KEY) begin
                  r_key <= w_shift_in;
                end else begin
                  r_block_in <= w_shift_in;
                  r_start    <= 1'b1;
                end
                r_state  <= S_DRAIN;
                r_cnt    <= {CW{1'b0}};
                r_shadow <= {PW{1'b0}};
              end else begin
                r_shadow <= w_shift_in;
                r_cnt    <= r_cnt + CW'(1);
              end
            end
          end
          S_READ: begin
            if (rx_done) begin
              if (w_last) begin
                r_state   <= S_DRAIN;
                r_cnt     <= {CW{1'b0}};
                r_err     <= 1'b0;
                r_tx_byte <= w_status;
              end else begin
                r_cnt     <= r_cnt + CW'(1);
                r_tx_byte <= byte_at(r_result, 32'(r_cnt) + 32'd1);
              end
            end
          end
          S_DRAIN: begin
            r_tx_byte <= w_status;
          end
          default: begin
            r_state   <= S_IDLE;
            r_tx_byte <= w_status;
          end
        endcase
      end
    end
  end

  assign tx_byte  = r_tx_byte;
  assign key      = r_key;
  assign block_in = r_block_in;
  assign start    = r_start;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_aes_spi_framer.sv
// Directed bench for aes_spi_framer: table of SPI frames plus hand-written
// sequences for AES completion, result readout and mid-transfer reset.
module tb_aes_spi_framer;

  logic         clk;
  logic         rst;
  logic         ss;
  logic         rx_done;
  logic [7:0]   rx_byte;
  logic [7:0]   tx_byte;
  logic [127:0] key;
  logic [127:0] block_in;
  logic         start;
  logic         aes_done;
  logic [127:0] block_out;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;
  int n_start = 0;

  aes_spi_framer #(.NBYTES(16)) dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_done(rx_done), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .key(key), .block_in(block_in), .start(start),
    .aes_done(aes_done), .block_out(block_out), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) n_start = n_start + 1;
  end

  typedef struct {
    logic [7:0]   cmd;
    int           npay;
    logic [7:0]   base;
    logic [7:0]   inc;
    logic         dwc;
    logic [127:0] exp_key;
    logic [127:0] exp_blk;
    logic         exp_last_start;
    int           exp_starts;
    logic         exp_busy;
    logic         exp_err;
    logic [7:0]   exp_tx;
  } frame_t;

  frame_t rows [8];

  localparam logic [127:0] K1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2  = 128'h102030405060708090A0B0C0D0E0F000;
  localparam logic [127:0] P1  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] P2  = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] P3  = 128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0;
  localparam logic [127:0] CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] Z   = 128'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int npay, input logic [7:0] base,
                           input logic [7:0] inc, input logic dwc, output logic last_start);
    ss = 1'b0;
    step();
    step();
    rx_byte  = cmd;
    rx_done  = 1'b1;
    aes_done = dwc;
    step();
    rx_done  = 1'b0;
    aes_done = 1'b0;
    step();
    last_start = 1'b0;
    for (int i = 0; i < npay; i++) begin
      rx_byte = base + inc * 8'(i);
      rx_done = 1'b1;
      step();
      if (i == npay - 1) last_start = start;
      rx_done = 1'b0;
      step();
    end
    ss = 1'b1;
    step();
    step();
  endtask

  task automatic do_read(input string tag, input logic [127:0] exp_res);
    logic [7:0] eb;
    ss = 1'b0;
    step();
    step();
    rx_byte = 8'h03;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    eb = exp_res[127 -: 8];
    chk({tag, "_b0"}, 128'(tx_byte), 128'(eb));
    step();
    for (int k = 1; k <= 16; k++) begin
      rx_byte = 8'(k);
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      if (k < 16) begin
        eb = exp_res[127 - 8*k -: 8];
        chk($sformatf("%s_b%0d", tag, k), 128'(tx_byte), 128'(eb));
      end else begin
        chk({tag, "_status_end"}, 128'(tx_byte), 128'h00);
        chk({tag, "_err_end"}, 128'(err), 128'h0);
      end
      step();
    end
    ss = 1'b1;
    step();
    step();
  endtask

  task automatic run_row(input int r);
    logic ls;
    run_frame(rows[r].cmd, rows[r].npay, rows[r].base, rows[r].inc, rows[r].dwc, ls);
    chk($sformatf("row%0d_key", r), key, rows[r].exp_key);
    chk($sformatf("row%0d_block_in", r), block_in, rows[r].exp_blk);
    chk($sformatf("row%0d_start_at_last", r), 128'(ls), 128'(rows[r].exp_last_start));
    chk($sformatf("row%0d_start_count", r), 128'(n_start), 128'(rows[r].exp_starts));
    chk($sformatf("row%0d_busy", r), 128'(busy), 128'(rows[r].exp_busy));
    chk($sformatf("row%0d_err", r), 128'(err), 128'(rows[r].exp_err));
    chk($sformatf("row%0d_status", r), 128'(tx_byte), 128'(rows[r].exp_tx));
  endtask

  initial begin
    logic ls;
    //           cmd    npay base   inc    dwc   key  blk  lst   n  busy  err   tx
    rows[0] = '{8'h01, 16, 8'h00, 8'h01, 1'b0, K1, Z,  1'b0, 0, 1'b0, 1'b0, 8'h00};
    rows[1] = '{8'h01,  7, 8'hAA, 8'h01, 1'b0, K1, Z,  1'b0, 0, 1'b0, 1'b0, 8'h00};
    rows[2] = '{8'h01, 16, 8'h10, 8'h10, 1'b0, K2, Z,  1'b0, 0, 1'b0, 1'b0, 8'h00};
    rows[3] = '{8'h02, 16, 8'h00, 8'h11, 1'b0, K2, P1, 1'b1, 1, 1'b1, 1'b0, 8'h02};
    rows[4] = '{8'h02, 16, 8'h55, 8'h00, 1'b0, K2, P1, 1'b0, 1, 1'b1, 1'b1, 8'h02};
    rows[5] = '{8'h7E, 16, 8'h01, 8'h01, 1'b0, K2, P1, 1'b0, 1, 1'b0, 1'b1, 8'h00};
    rows[6] = '{8'h02, 16, 8'h01, 8'h01, 1'b0, K2, P2, 1'b1, 2, 1'b1, 1'b1, 8'h02};
    rows[7] = '{8'h02, 16, 8'hF0, 8'h00, 1'b1, K2, P3, 1'b1, 3, 1'b1, 1'b1, 8'h03};

    rst = 1'b0; ss = 1'b1; rx_done = 1'b0; rx_byte = 8'h00;
    aes_done = 1'b0; block_out = 128'h0;
    step();
    step();
    chk("reset_key", key, Z);
    chk("reset_block_in", block_in, Z);
    chk("reset_start", 128'(start), 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    chk("reset_err", 128'(err), 128'h0);
    chk("reset_tx", 128'(tx_byte), 128'h00);
    rst = 1'b1;
    step();

    do_read("read_empty", Z);

    for (int r = 0; r < 5; r++) run_row(r);

    block_out = CT;
    aes_done  = 1'b1;
    step();
    aes_done  = 1'b0;
    block_out = 128'h0;
    chk("aes_done_busy", 128'(busy), 128'h0);
    chk("aes_done_status", 128'(tx_byte), 128'h01);
    step();
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    chk("aes_done_idle_ignored", 128'(tx_byte), 128'h01);

    do_read("read_ct", CT);

    block_out = 128'hDEADBEEF;
    for (int r = 5; r < 8; r++) run_row(r);

    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    ss = 1'b0;
    step();
    step();
    rx_byte = 8'h02; rx_done = 1'b1; step(); rx_done = 1'b0; step();
    for (int i = 0; i < 8; i++) begin
      rx_byte = 8'(i); rx_done = 1'b1; step(); rx_done = 1'b0; step();
    end
    rx_byte = 8'h08; rx_done = 1'b1; rst = 1'b0;
    step();
    rx_done = 1'b0;
    chk("midrst_key", key, Z);
    chk("midrst_block_in", block_in, Z);
    chk("midrst_start", 128'(start), 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_err", 128'(err), 128'h0);
    chk("midrst_tx", 128'(tx_byte), 128'h00);
    ss = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    chk("midrst_status", 128'(tx_byte), 128'h00);
    chk("midrst_no_start", 128'(n_start), 128'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_spi_framer.md
AES_SPI_FRAMER -- requirements
Module: aes_spi_framer

Interface
REQ-001 SHALL have parameter NBYTES, default 16, the number of payload bytes per key, plaintext and ciphertext transfer.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset, sampled on the clk rising edge (0 = reset).
REQ-004 SHALL have port ss  input  1  SPI slave select, already synchronised (1 = deselected, frame boundary).
REQ-005 SHALL have port rx_done  input  1  one-cycle pulse: SPI slave completed a byte.
REQ-006 SHALL have port rx_byte  input  8  received byte, valid when rx_done=1.
REQ-007 SHALL have port tx_byte  output  8  next byte for the SPI slave to shift out.
REQ-008 SHALL have port key  output  8*NBYTES  committed AES key, with the first-received byte in the MSBs.
REQ-009 SHALL have port block_in  output  8*NBYTES  committed plaintext, with the first-received byte in the MSBs.
REQ-010 SHALL have port start  output  1  one-cycle pulse requesting encryption of block_in with key.
REQ-011 SHALL have port aes_done  input  1  one-cycle pulse: block_out is valid.
REQ-012 SHALL have port block_out  input  8*NBYTES  ciphertext from the AES core.
REQ-013 SHALL have port busy  output  1  high from start until aes_done.
REQ-014 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, LOAD_KEY, LOAD_PT, READ, DRAIN.
REQ-016 SHALL move from any state to IDLE in the cycle after ss=1 is sampled, and SHALL move from IDLE to CMD when ss=0.
REQ-017 SHALL ignore rx_done while ss=1.
REQ-018 SHALL decode the first rx_done byte in CMD: 0x01 -> LOAD_KEY; 0x02 -> LOAD_PT; 0x03 -> READ; any other value -> DRAIN with err set.
REQ-019 SHALL shift each byte received in LOAD_KEY or LOAD_PT into a shadow register and count bytes 0..NBYTES-1 with a byte counter.
REQ-020 SHALL copy the shadow register into key in the cycle after the NBYTES-th LOAD_KEY byte, then enter DRAIN.
REQ-021 SHALL copy the shadow register into block_in and pulse start in the cycle after the NBYTES-th LOAD_PT byte, then set busy and enter DRAIN.
REQ-022 SHALL leave key and block_in unchanged when ss rises before the NBYTES-th payload byte; the partial shadow data is discarded and the counter cleared.
REQ-023 SHALL, when command 0x02 arrives while busy=1, set err, issue no start, leave block_in unchanged, and enter DRAIN.
REQ-024 SHALL ignore all bytes in DRAIN until ss rises.
REQ-025 SHALL, on aes_done, latch block_out into an internal result register, set result_valid, and clear busy; aes_done while busy=0 is ignored.
REQ-026 SHALL, in READ, drive tx_byte with result byte k (k=0 being the MSB byte) from the cycle after the command byte's or byte k-1's rx_done until the next rx_done.
REQ-027 SHALL enter DRAIN after NBYTES READ bytes, and SHALL clear result_valid and err at that point.
REQ-028 SHALL drive tx_byte = {6'b0, busy, result_valid} in IDLE, CMD, LOAD_KEY, LOAD_PT and DRAIN.
REQ-029 SHALL, on command 0x03 with result_valid=0, return the result register (all zeros after reset) without setting err.
REQ-030 SHALL give aes_done priority over a simultaneous 0x02 command byte: busy clears first, so the command is accepted.

Reset
REQ-031 SHALL, while rst=0 at a clk edge, set FSM=IDLE, counter=0, key=0, block_in=0, result=0, start=0, busy=0, result_valid=0, err=0, and tx_byte=0x00.
REQ-032 SHALL, when reset is applied mid-transfer, abandon the transfer with no commit and no start pulse.

Verification
REQ-033 Key load: ss=0, bytes 0x01, 0x00..0x0F, ss=1 -> key=0x000102...0F; start never pulses.
REQ-034 Plaintext: bytes 0x02, 0x00,0x11,...,0xFF -> one start pulse 1 cycle after last byte; block_in=0x0011...FF; busy=1, tx_byte status=0x02.
REQ-035 Result: aes_done with block_out=0x69C4E0D8...C55A, then frame 0x03 + 16 dummy bytes -> tx_byte sequence 0x69,0xC4,...,0x5A; status afterwards 0x00.
REQ-036 Abort: 0x01 + 7 bytes, then ss=1 -> key unchanged; next full key load succeeds.
REQ-037 Errors: command 0x7E -> err=1 and rest of frame ignored; 0x02 sent while busy -> err=1, no start.
REQ-038 Reset: rst=0 during LOAD_PT byte 9 -> all outputs zero, no start; status byte 0x00.
